// File: rtl/instr_fetch_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : instr_fetch_ctrl                                           |
// | Description : LC3 instruction fetch controller. Issues instruction       |
// |               memory reads against a credit budget, tracks in-flight     |
// |               requests over a fixed read latency, buffers returned words |
// |               and hands them to decode under valid/ready. A redirect     |
// |               flushes everything and restarts fetch at a new address.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module instr_fetch_ctrl #(
   parameter logic [15:0] RESET_PC = 16'h3000,
   parameter int          MEM_LAT  = 1,
   parameter int          DEPTH    = 4
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        enable_fetch,
   input  logic        redirect,
   input  logic [15:0] redirect_pc,
   output logic        imem_rd,
   output logic [15:0] imem_addr,
   input  logic [15:0] imem_dout,
   output logic        instr_valid,
   output logic [15:0] instr,
   output logic [15:0] instr_pc,
   output logic [15:0] npc,
   input  logic        instr_ready
);

   // Buffer pointer width, occupancy width and a wider width that can hold
   // occupancy plus every in-flight request without overflow.
   localparam int              c_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int              c_CW    = c_AW + 1;
   localparam int              c_SW    = c_CW + 2;
   localparam logic [c_SW-1:0] c_DEPTH = c_SW'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_STALL = 2'd2
   } state_t;

   state_t                 r_state;
   logic [15:0]            r_pc;
   logic [MEM_LAT-1:0]     r_inf_v;
   logic [MEM_LAT*16-1:0]  r_inf_pc;
   logic [15:0]            r_buf_instr [DEPTH];
   logic [15:0]            r_buf_pc    [DEPTH];
   logic [c_AW-1:0]        r_rd_ptr;
   logic [c_AW-1:0]        r_wr_ptr;
   logic [c_CW-1:0]        r_count;

   logic [c_SW-1:0]        w_used;
   logic                   w_credit;
   logic                   w_ret;
   logic [15:0]            w_ret_pc;
   logic                   w_push;
   logic                   w_pop;
   logic [MEM_LAT-1:0]     w_inf_v_nxt;
   logic [MEM_LAT*16-1:0]  w_inf_pc_nxt;
   logic [15:0]            w_head_instr;
   logic [15:0]            w_head_pc;

   // Slots already committed: buffered words plus requests still in flight.
   always_comb begin
      w_used = c_SW'(r_count);
      for (int i = 0; i < MEM_LAT; i++) begin
         w_used = w_used + c_SW'(r_inf_v[i]);
      end
   end

   // Credit comes from registered state only, so a same-cycle pop never
   // frees a slot early.
   assign w_credit  = (w_used < c_DEPTH);
   assign imem_rd   = (r_state == S_FETCH) && w_credit && !redirect;
   assign imem_addr = r_pc;

   // The oldest in-flight stage is the one whose data is on imem_dout now.
   assign w_ret    = r_inf_v[MEM_LAT-1];
   assign w_ret_pc = r_inf_pc[MEM_LAT*16-1 -: 16];
   assign w_push   = w_ret && !redirect;

   assign instr_valid  = (r_count != '0) && !redirect;
   assign w_pop        = instr_valid && instr_ready;
   assign w_head_instr = r_buf_instr[r_rd_ptr];
   assign w_head_pc    = r_buf_pc[r_rd_ptr];
   assign instr        = instr_valid ? w_head_instr : 16'h0000;
   assign instr_pc     = instr_valid ? w_head_pc : 16'h0000;
   assign npc          = instr_valid ? (w_head_pc + 16'd1) : 16'h0000;

   // Next value of the in-flight pipeline: a new request enters stage 0.
   generate
      if (MEM_LAT > 1) begin : g_shift
         assign w_inf_v_nxt  = {r_inf_v[MEM_LAT-2:0], imem_rd};
         assign w_inf_pc_nxt = {r_inf_pc[(MEM_LAT-1)*16-1:0], r_pc};
      end else begin : g_single
         assign w_inf_v_nxt  = imem_rd;
         assign w_inf_pc_nxt = r_pc;
      end
   endgenerate

   // Fetch state: idle, issuing, or waiting for a free credit.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else if (redirect) begin
         if (r_state == S_STALL) begin
            r_state <= S_FETCH;
         end
      end else begin
         case (r_state)
            S_IDLE: begin
               if (enable_fetch) r_state <= S_FETCH;
            end
            S_FETCH: begin
               if (!enable_fetch)  r_state <= S_IDLE;
               else if (!w_credit) r_state <= S_STALL;
            end
            S_STALL: begin
               if (!enable_fetch) r_state <= S_IDLE;
               else if (w_credit) r_state <= S_FETCH;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Fetch PC: reload on redirect, advance by one per issued request.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_pc <= RESET_PC;
      end else if (redirect) begin
         r_pc <= redirect_pc;
      end else if (imem_rd) begin
         r_pc <= r_pc + 16'd1;
      end
   end

   // In-flight tracking; a redirect kills every outstanding request.
   always_ff @(posedge clock) begin
      if (!reset_n || redirect) begin
         r_inf_v <= '0;
      end else begin
         r_inf_v <= w_inf_v_nxt;
      end
      r_inf_pc <= w_inf_pc_nxt;
   end

   // Buffer storage: capture returning words with the address they came from.
   always_ff @(posedge clock) begin
      if (w_push) begin
         r_buf_instr[r_wr_ptr] <= imem_dout;
         r_buf_pc[r_wr_ptr]    <= w_ret_pc;
      end
   end

   // Buffer pointers and occupancy; a simultaneous push and pop cancel out.
   always_ff @(posedge clock) begin
      if (!reset_n || redirect) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_CW'(1);
            2'b01:   r_count <= r_count - c_CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
`default_nettype wire
